y86_seq_ctrl: RTL and testbench

Y86_SEQ_CTRL -- requirements
Module: y86_seq_ctrl

---
 rtl/y86_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_y86_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_ctrl.sv
// Sequential Y86-64 control unit: walks each instruction through fetch, decode,
// execute, memory, writeback and PC update, with ack timeouts and sticky fault states.
module y86_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        imem_ack,
  input  logic [3:0]  icode,
  input  logic        imem_error,
  input  logic        dmem_ack,
  input  logic        dmem_error,
  input  logic        cnd,
  output logic        imem_req,
  output logic        decode_en,
  output logic        exec_en,
  output logic        cc_we,
  output logic        dmem_req,
  output logic        dmem_write,
  output logic        reg_we,
  output logic        pc_we,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] instr_cnt
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
    S_WRITEBACK, S_PCUPDATE, S_HALT, S_ERROR
  } state_t;

  state_t              r_state;
  logic [3:0]          r_icode;
  logic                r_cnd;
  logic [WAIT_W-1:0]   r_wait;

  state_t              w_next_state;
  logic [2:0]          w_next_stat;
  logic [3:0]          w_next_icode;
  logic                w_next_cnd;
  logic [WAIT_W-1:0]   w_next_wait;
  logic                w_timeout;

  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

  // Next-state logic; an ack always wins over a coincident timeout.
  always_comb begin
    w_next_state = r_state;
    w_next_stat  = stat;
    w_next_icode = r_icode;
    w_next_cnd   = r_cnd;
    w_next_wait  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_next_wait  = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_next_icode = icode;
          if (imem_error) begin
            w_next_state = S_ERROR;
            w_next_stat  = STAT_ADR;
          end else if (icode > 4'd11) begin
            w_next_state = S_ERROR;
            w_next_stat  = STAT_INS;
          end else if (icode == 4'd0) begin
            w_next_state = S_HALT;
            w_next_stat  = STAT_HLT;
          end else begin
            w_next_state = S_DECODE;
          end
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
          w_next_stat  = STAT_ADR;
        end else begin
          w_next_wait = r_wait + WAIT_W'(1);
        end
      end
      S_DECODE: w_next_state = S_EXECUTE;
      S_EXECUTE: begin
        w_next_cnd = cnd;
        case (r_icode) inside
          4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: begin
            w_next_state = S_MEMORY;
            w_next_wait  = '0;
          end
          4'd2, 4'd3, 4'd6: w_next_state = S_WRITEBACK;
          default:          w_next_state = S_PCUPDATE;
        endcase
      end
      S_MEMORY: begin
        if (dmem_ack) begin
          if (dmem_error) begin
            w_next_state = S_ERROR;
            w_next_stat  = STAT_ADR;
          end else if (r_icode == 4'd4) begin
            w_next_state = S_PCUPDATE;
          end else begin
            w_next_state = S_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
          w_next_stat  = STAT_ADR;
        end else begin
          w_next_wait = r_wait + WAIT_W'(1);
        end
      end
      S_WRITEBACK: w_next_state = S_PCUPDATE;
      S_PCUPDATE: begin
        w_next_state = S_FETCH;
        w_next_wait  = '0;
      end
      S_HALT:  w_next_state = S_HALT;
      S_ERROR: w_next_state = S_ERROR;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State and outputs registered together; outputs are decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_icode    <= 4'd0;
      r_cnd      <= 1'b0;
      r_wait     <= '0;
      stat       <= STAT_AOK;
      instr_cnt  <= 32'd0;
      imem_req   <= 1'b0;
      decode_en  <= 1'b0;
      exec_en    <= 1'b0;
      cc_we      <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_write <= 1'b0;
      reg_we     <= 1'b0;
      pc_we      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_icode    <= w_next_icode;
      r_cnd      <= w_next_cnd;
      r_wait     <= w_next_wait;
      stat       <= w_next_stat;
      if (r_state == S_PCUPDATE) instr_cnt <= instr_cnt + 32'd1;
      imem_req   <= (w_next_state == S_FETCH);
      decode_en  <= (w_next_state == S_DECODE);
      exec_en    <= (w_next_state == S_EXECUTE);
      cc_we      <= (w_next_state == S_EXECUTE) && (w_next_icode == 4'd6);
      dmem_req   <= (w_next_state == S_MEMORY);
      dmem_write <= (w_next_state == S_MEMORY) &&
                    (w_next_icode inside {4'd4, 4'd8, 4'd10});
      reg_we     <= (w_next_state == S_WRITEBACK) &&
                    !((w_next_icode == 4'd2) && !w_next_cnd);
      pc_we      <= (w_next_state == S_PCUPDATE);
      busy       <= !(w_next_state inside {S_IDLE, S_HALT, S_ERROR});
    end
  end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Self-checking bench for y86_seq_ctrl: per-instruction behavioural model driving
// expected outputs cycle by cycle, directed scenarios plus a randomized program.
module tb_y86_seq_ctrl;

  localparam int unsigned TO = 4;

  // Expected-enable bit positions: {imem_req,decode_en,exec_en,cc_we,dmem_req,dmem_write,reg_we,pc_we}
  localparam logic [7:0] E_FET = 8'b1000_0000;
  localparam logic [7:0] E_DEC = 8'b0100_0000;
  localparam logic [7:0] E_EXE = 8'b0010_0000;
  localparam logic [7:0] E_CC  = 8'b0001_0000;
  localparam logic [7:0] E_MEM = 8'b0000_1000;
  localparam logic [7:0] E_WR  = 8'b0000_0100;
  localparam logic [7:0] E_RW  = 8'b0000_0010;
  localparam logic [7:0] E_PC  = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, imem_ack = 1'b0, imem_error = 1'b0;
  logic dmem_ack = 1'b0, dmem_error = 1'b0, cnd = 1'b0;
  logic [3:0] icode = 4'd0;
  logic imem_req, decode_en, exec_en, cc_we, dmem_req, dmem_write, reg_we, pc_we, busy;
  logic [2:0] stat;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  y86_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_ack(imem_ack), .icode(icode),
    .imem_error(imem_error), .dmem_ack(dmem_ack), .dmem_error(dmem_error), .cnd(cnd),
    .imem_req(imem_req), .decode_en(decode_en), .exec_en(exec_en), .cc_we(cc_we),
    .dmem_req(dmem_req), .dmem_write(dmem_write), .reg_we(reg_we), .pc_we(pc_we),
    .stat(stat), .busy(busy), .instr_cnt(instr_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_dreq = 0, n_ireq = 0, n_rwe = 0;

  logic        chk_en = 1'b0;
  logic [7:0]  e_en   = 8'd0;
  logic [2:0]  e_stat = 3'd1;
  logic        e_busy = 1'b0;
  string       e_phase = "reset";

  logic [31:0] m_cnt  = 32'd0;
  logic [2:0]  m_stat = 3'd1;
  logic        m_dead = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Per-cycle comparison of every output against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check({"outputs/", e_phase},
            32'({imem_req, decode_en, exec_en, cc_we, dmem_req, dmem_write, reg_we, pc_we, busy, stat}),
            32'({e_en, e_busy, e_stat}));
      check({"instr_cnt/", e_phase}, instr_cnt, m_cnt);
      n_dreq += int'(dmem_req);
      n_ireq += int'(imem_req);
      n_rwe  += int'(reg_we);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input string ph, input logic [7:0] en, input logic [2:0] st, input logic b);
    e_phase = ph; e_en = en; e_stat = st; e_busy = b;
  endtask

  task automatic noise();
    start = 1'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    imem_error = 1'($urandom); dmem_error = 1'($urandom);
    cnd = 1'($urandom); icode = 4'($urandom);
  endtask

  task automatic fault(input logic [2:0] st);
    m_stat = st;
    m_dead = 1'b1;
    set_exp(st == 3'd2 ? "halt" : "error", 8'd0, st, 1'b0);
  endtask

  task automatic do_reset();
    start = 0; imem_ack = 0; dmem_ack = 0; imem_error = 0; dmem_error = 0; cnd = 0; icode = 0;
    m_cnt = 32'd0; m_stat = 3'd1; m_dead = 1'b0;
    set_exp("idle", 8'd0, 3'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'({imem_req, decode_en, exec_en, cc_we, dmem_req, dmem_write, reg_we, pc_we, busy}), 32'd0);
    check("reset_stat", 32'(stat), 32'd1);
    check("reset_cnt", instr_cnt, 32'd0);
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      noise(); start = 1'b0;
      tick();
    end
  endtask

  // Leaves the DUT in FETCH for the current cycle.
  task automatic do_start();
    noise(); start = 1'b1;
    set_exp("idle", 8'd0, 3'd1, 1'b0);
    tick();
  endtask

  // Model of one instruction from FETCH entry. stop_mem returns mid-MEMORY without advancing.
  task automatic run_instr(input logic [3:0] ic, input int ilat, input logic ierr, input logic c,
                           input int dlat, input logic derr, input bit stop_mem);
    bit is_mem, is_wb;
    for (int k = 0; ; k++) begin
      noise(); imem_ack = (k == ilat);
      if (k == ilat) begin icode = ic; imem_error = ierr; end
      set_exp("fetch", E_FET, 3'd1, 1'b1);
      tick();
      if (k == ilat) break;
      if (k + 1 == int'(TO)) begin fault(3'd3); return; end
    end
    if (ierr)           begin fault(3'd3); return; end
    if (ic > 4'd11)     begin fault(3'd4); return; end
    if (ic == 4'd0)     begin fault(3'd2); return; end
    noise(); set_exp("decode", E_DEC, 3'd1, 1'b1); tick();
    noise(); cnd = c;
    set_exp("execute", E_EXE | ((ic == 4'd6) ? E_CC : 8'd0), 3'd1, 1'b1);
    tick();
    is_mem = (ic == 4) || (ic == 5) || (ic >= 8);
    is_wb  = (ic == 2) || (ic == 3) || (ic == 6);
    if (is_mem) begin
      for (int k = 0; ; k++) begin
        if (stop_mem) return;
        noise(); dmem_ack = (k == dlat);
        if (k == dlat) dmem_error = derr;
        set_exp("memory", E_MEM | ((ic == 4 || ic == 8 || ic == 10) ? E_WR : 8'd0), 3'd1, 1'b1);
        tick();
        if (k == dlat) break;
        if (k + 1 == int'(TO)) begin fault(3'd3); return; end
      end
      if (derr) begin fault(3'd3); return; end
      is_wb = (ic != 4'd4);
    end
    if (is_wb) begin
      noise();
      set_exp("writeback", (ic == 4'd2 && !c) ? 8'd0 : E_RW, 3'd1, 1'b1);
      tick();
    end
    noise(); set_exp("pcupdate", E_PC, 3'd1, 1'b1); tick();
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic linger(input int n);
    for (int i = 0; i < n; i++) begin
      noise(); start = 1'b1;
      set_exp("absorb", 8'd0, m_stat, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [3:0] ic;
    set_exp("idle", 8'd0, 3'd1, 1'b0);
    tick();
    do_reset();

    // irmovq, cmovXX not taken, rmmovq with 3-cycle data latency
    do_start();
    n_rwe = 0;
    run_instr(4'd3, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("irmovq_cnt", instr_cnt, 32'd1);
    check("irmovq_reg_we_cycles", 32'(n_rwe), 32'd1);
    n_rwe = 0;
    run_instr(4'd2, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("cmov_nt_reg_we_cycles", 32'(n_rwe), 32'd0);
    check("cmov_cnt", instr_cnt, 32'd2);
    n_rwe = 0; n_dreq = 0;
    run_instr(4'd4, 0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    check("rmmovq_dmem_req_cycles", 32'(n_dreq), 32'd4);
    check("rmmovq_reg_we_cycles", 32'(n_rwe), 32'd0);
    check("rmmovq_cnt", instr_cnt, 32'd3);

    // halt, then start is ignored
    run_instr(4'd0, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("halt_stat", 32'(stat), 32'd2);
    check("halt_busy", 32'(busy), 32'd0);
    linger(4);

    // illegal instruction, then data address fault on mrmovq
    do_reset(); do_start();
    run_instr(4'd12, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("ins_stat", 32'(stat), 32'd4);
    linger(2);
    do_reset(); do_start();
    run_instr(4'd5, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    check("mrmovq_adr_stat", 32'(stat), 32'd3);
    linger(2);

    // fetch timeout
    do_reset(); do_start();
    n_ireq = 0;
    run_instr(4'd3, 100, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("timeout_fetch_cycles", 32'(n_ireq), 32'd4);
    check("timeout_stat", 32'(stat), 32'd3);
    linger(2);

    // reset asserted while in MEMORY
    do_reset(); do_start();
    run_instr(4'd3, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(4'd5, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    #1;
    check("pre_reset_in_memory", 32'(dmem_req), 32'd1);
    do_reset();
    check("post_reset_cnt", instr_cnt, 32'd0);

    // randomized program
    do_start();
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 24));
      if (r < 21)       ic = 4'($urandom_range(1, 11));
      else if (r == 21) ic = 4'd0;
      else              ic = 4'($urandom_range(12, 15));
      run_instr(ic,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2)),
                $urandom_range(0, 29) == 0, 1'($urandom),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2)),
                $urandom_range(0, 19) == 0, 1'b0);
      if (m_dead) begin
        linger(int'($urandom_range(1, 3)));
        do_reset(); do_start();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
